// File: rtl/cut_auto_ctl.sv
// Automatic cut (truncation) selector: tracks per-frame minimum redundant-sign count of I/Q
// and picks the downstream cut. Define CUT_HYST_EN to add gain-increase hysteresis.
module cut_auto_ctl #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] data_i,
    input  logic [LEN-1:0] data_q,
    input  logic           in_valid,
    input  logic           frame_start,
    input  logic           manual_en,
    input  logic [2:0]     manual_cut,
    output logic [2:0]     cut_ctl,
    output logic           cut_update,
    output logic [5:0]     peak_nrs
);

    localparam logic [5:0] LEN6 = 6'(LEN);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

    function automatic logic [5:0] nrs(input logic [LEN-1:0] x);
        logic [5:0] cnt;
        logic       run;
        cnt = 6'd0;
        run = 1'b1;
        for (int b = LEN - 1; b >= 0; b--) begin
            if (run && (x[b] == x[LEN-1])) begin
                cnt = cnt + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    // fmin of 1 means no headroom at all, so fall back to the plain top-16 take
    function automatic logic [2:0] cand(input logic [5:0] f);
        logic [5:0] d;
        d = f - 6'd2;
        if (f >= 6'd8) begin
            return 3'd6;
        end else if (f >= 6'd2) begin
            return d[2:0];
        end else begin
            return 3'd7;
        end
    endfunction

`ifdef CUT_HYST_EN
    function automatic logic [2:0] rank(input logic [2:0] c);
        return (c == 3'd7) ? 3'd0 : (c + 3'd1);
    endfunction
`endif

    logic [5:0] w_ni, w_nq;
    logic [5:0] r_m;
    logic       r_vld, r_fs;
    state_t     r_state, w_state_nxt;
    logic [5:0] r_fmin, w_fmin_nxt;
    logic       r_ne, w_ne_nxt;
    logic [2:0] r_cut, w_cut_nxt;
    logic       r_upd, w_upd_nxt;
    logic [5:0] r_peak, w_peak_nxt;
    logic       w_close, w_apply;
    logic [2:0] w_cand, w_apply_cut;
`ifdef CUT_HYST_EN
    logic       r_pend, w_pend_nxt;
    logic [2:0] r_pcut, w_pcut_nxt;
`endif

    assign w_ni = nrs(data_i);
    assign w_nq = nrs(data_q);

    // Stage 1: per-sample minimum sign count, qualifiers delayed to match
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= LEN6;
            r_vld <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_m   <= (w_ni < w_nq) ? w_ni : w_nq;
            r_vld <= in_valid;
            r_fs  <= frame_start;
        end
    end

    // Next-state, frame accumulation and cut decision
    always_comb begin
        w_state_nxt = r_state;
        w_fmin_nxt  = r_fmin;
        w_ne_nxt    = r_ne;
        w_cut_nxt   = r_cut;
        w_upd_nxt   = 1'b0;
        w_peak_nxt  = r_peak;
        w_close     = 1'b0;
        w_apply     = 1'b0;
        w_apply_cut = r_cut;
        w_cand      = cand(r_fmin);
`ifdef CUT_HYST_EN
        w_pend_nxt  = r_pend;
        w_pcut_nxt  = r_pcut;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_fs) begin
                    w_state_nxt = S_ACCUM;
                    w_fmin_nxt  = r_vld ? r_m : LEN6;
                    w_ne_nxt    = r_vld;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (r_fs) begin
                    w_close    = 1'b1;
                    w_fmin_nxt = r_vld ? r_m : LEN6;
                    w_ne_nxt   = r_vld;
                end else if (r_vld) begin
                    w_fmin_nxt = (r_m < r_fmin) ? r_m : r_fmin;
                    w_ne_nxt   = 1'b1;
                end else begin
                    w_fmin_nxt = r_fmin;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_close && r_ne) begin
            w_peak_nxt = r_fmin;
`ifdef CUT_HYST_EN
            if (rank(w_cand) > rank(r_cut)) begin
                if (r_pend) begin
                    w_apply     = 1'b1;
                    w_apply_cut = (rank(w_cand) < rank(r_pcut)) ? w_cand : r_pcut;
                    w_pend_nxt  = 1'b0;
                end else begin
                    w_pend_nxt = 1'b1;
                    w_pcut_nxt = w_cand;
                end
            end else begin
                w_apply     = 1'b1;
                w_apply_cut = w_cand;
                w_pend_nxt  = 1'b0;
            end
`else
            w_apply     = 1'b1;
            w_apply_cut = w_cand;
`endif
        end else if (w_close) begin
`ifdef CUT_HYST_EN
            w_pend_nxt = 1'b0;
`endif
        end else begin
            w_peak_nxt = r_peak;
        end

        if (manual_en) begin
            w_cut_nxt = manual_cut;
        end else if (w_apply) begin
            w_cut_nxt = w_apply_cut;
            w_upd_nxt = 1'b1;
        end else begin
            w_cut_nxt = r_cut;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fmin  <= LEN6;
            r_ne    <= 1'b0;
            r_cut   <= 3'd7;
            r_upd   <= 1'b0;
            r_peak  <= LEN6;
`ifdef CUT_HYST_EN
            r_pend  <= 1'b0;
            r_pcut  <= 3'd7;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_fmin  <= w_fmin_nxt;
            r_ne    <= w_ne_nxt;
            r_cut   <= w_cut_nxt;
            r_upd   <= w_upd_nxt;
            r_peak  <= w_peak_nxt;
`ifdef CUT_HYST_EN
            r_pend  <= w_pend_nxt;
            r_pcut  <= w_pcut_nxt;
`endif
        end
    end

    assign cut_ctl    = r_cut;
    assign cut_update = r_upd;
    assign peak_nrs   = r_peak;

endmodule
